pwm_driver: RTL and testbench
=============================

PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16, command word width in bits.
REQ-002 SHALL have parameter QBITS, default 8, fractional bits of the command; full scale 1.0 = 1<<QBITS.
REQ-003 SHALL have parameter PERIOD, default 'h100, PWM period in clocks; legal range 2 <= PERIOD < 2^WIDTH.
REQ-004 SHALL have parameter DEADTIME, default 4, clocks with both outputs low on a direction reversal; legal range 0 <= DEADTIME < PERIOD.
REQ-005 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port i_cmd, input, signed WIDTH, drive command in QBITS fixed point, as produced by the team's PID controller output.
REQ-008 SHALL have port i_cmd_valid, input, 1, capture strobe for i_cmd.
REQ-009 SHALL have port i_enable, input, 1, drive enable.
REQ-010 SHALL have port o_pwm_a, output, 1, forward-leg gate drive.
REQ-011 SHALL have port o_pwm_b, output, 1, reverse-leg gate drive.
REQ-012 SHALL have port o_dir, output, 1, 0 = forward, 1 = reverse, for the current period.
REQ-013 SHALL have port o_sat, output, 1, current period's command was clipped.
REQ-014 SHALL have port o_period_start, output, 1, high for exactly the first cycle of each period.

Function
REQ-015 SHALL capture i_cmd into a shadow register on every edge where i_cmd_valid=1; with several captures in one period, the last one wins.
REQ-016 SHALL run a free-running period counter 0..PERIOD-1 that wraps to 0; a period starts on each wrap.
REQ-017 SHALL load a shadow value only at a period start strictly after its capture edge; a capture on the same edge as a period start takes effect one period later.
REQ-018 SHALL compute magnitude = min(|cmd|, 1<<QBITS); cmd = -2^(WIDTH-1) SHALL saturate without overflow.
REQ-019 SHALL compute duty = (magnitude*PERIOD)>>QBITS, using a product width of at least WIDTH+clog2(PERIOD)+1; duty range 0..PERIOD.
REQ-020 SHALL hold o_sat=1 for the whole period when |cmd| > 1<<QBITS, else 0.
REQ-021 SHALL implement states IDLE, FWD, REV and DEAD, updated only at period start, except as given in REQ-026.
REQ-022 SHALL select the target state at period start: cmd>0 -> FWD; cmd<0 -> REV; cmd=0 or duty=0 -> IDLE.
REQ-023 SHALL enter DEAD for DEADTIME cycles on a direct FWD->REV or REV->FWD transition, with both outputs low, then proceed to the target state.
REQ-024 SHALL apply no dead time on transitions from IDLE.
REQ-025 SHALL drive the active leg high for counter values k with dead <= k < duty, where dead = DEADTIME if reversing else 0; the inactive leg stays low; if duty <= dead there is no pulse; duty = PERIOD gives a continuous high after dead time.
REQ-026 SHALL, on i_enable=0 sampled at an edge, force both outputs low from that edge and enter IDLE; the counter keeps running and the shadow register is retained.
REQ-027 SHALL, after re-enable, resume driving at the next period start with no dead time.
REQ-028 SHALL update o_dir only at period start, and only for a FWD or REV target; IDLE retains the last value.
REQ-029 SHALL never assert o_pwm_a and o_pwm_b in the same cycle under any input sequence.
REQ-030 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-031 SHALL, while i_rst_n=0, immediately force o_pwm_a=0, o_pwm_b=0, o_dir=0, o_sat=0, o_period_start=0, counter=0, shadow=0 and state=IDLE, including when reset is asserted mid-pulse.
REQ-032 SHALL treat the first rising edge after i_rst_n deasserts as period 0 start, with o_period_start=1 and shadow value 0, giving an idle period.

Verification (PERIOD=256, QBITS=8, DEADTIME=4)
REQ-033 SHALL cover: i_cmd=0x0080 captured -> from the next period, o_pwm_a high 128 cycles per period, o_pwm_b=0, o_dir=0, o_sat=0.
REQ-034 SHALL cover: 0x0100 for one period, then 0xFF00 -> o_pwm_a high 256 cycles; next period both outputs low for 4 cycles, then o_pwm_b high 252 cycles, o_dir=1.
REQ-035 SHALL cover: i_cmd=0x8000 -> o_sat=1 and o_pwm_b pulse width of 256 minus any dead time; 0x0180 -> o_sat=1 and o_pwm_a high 256 cycles.
REQ-036 SHALL cover: 0x0040 then 0x00C0 captured in one period -> next period 192 high cycles; a capture on the o_period_start edge is applied one period later.
REQ-037 SHALL cover: i_rst_n low mid-pulse -> outputs 0 without a clock edge; after release, o_period_start on the first edge and an idle period follows.
REQ-038 SHALL cover: i_enable low at counter 50 with duty 128 -> outputs low from the next edge; re-enable drives only from the following period start; a one-hot assertion on the two legs is checked throughout.

Source files
------------

// File: rtl/pwm_driver.sv
// ---------------------------------------------------------------------------
// pwm_driver
//
// H-bridge PWM generator driven by a signed fixed-point command.
//
// A command is captured into a shadow register whenever i_cmd_valid is high.
// At each period start the shadow value becomes the active command for that
// period. Its magnitude is clipped to 1.0 (1 << QBITS) and scaled to a duty
// count in clocks. On a direct forward/reverse reversal both legs stay low
// for DEADTIME clocks before the new leg is driven.
//
// Ports
//   i_clk          : sole clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_cmd          : signed drive command, QBITS fractional bits
//   i_cmd_valid    : capture strobe for i_cmd
//   i_enable       : drive enable; low forces both legs off and IDLE
//   o_pwm_a        : forward-leg gate drive
//   o_pwm_b        : reverse-leg gate drive
//   o_dir          : 0 = forward, 1 = reverse for the current period
//   o_sat          : active command of this period was clipped
//   o_period_start : high during the first cycle of every period
// ---------------------------------------------------------------------------
module pwm_driver #(
   parameter int WIDTH    = 16,
   parameter int QBITS    = 8,
   parameter int PERIOD   = 'h100,
   parameter int DEADTIME = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic signed [WIDTH-1:0] i_cmd,
   input  logic                    i_cmd_valid,
   input  logic                    i_enable,
   output logic                    o_pwm_a,
   output logic                    o_pwm_b,
   output logic                    o_dir,
   output logic                    o_sat,
   output logic                    o_period_start
);

   // Product is wide enough for |cmd| (WIDTH+1 bits) times PERIOD.
   localparam int               PW     = WIDTH + $clog2(PERIOD) + 2;
   localparam logic [WIDTH-1:0] LAST   = WIDTH'(PERIOD - 1);
   localparam logic [WIDTH-1:0] DEAD_W = WIDTH'(DEADTIME);
   localparam logic [WIDTH:0]   FULL   = (WIDTH+1)'(1) << QBITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      REV  = 2'd2,
      DEAD = 2'd3
   } state_t;

   logic [WIDTH-1:0]        cnt_reg;
   logic [WIDTH-1:0]        cnt_next;
   logic                    first_reg;
   logic signed [WIDTH-1:0] shadow_reg;
   state_t                  state_reg;
   state_t                  state_next;
   state_t                  target_reg;
   state_t                  target_next;
   state_t                  target_new;
   logic [WIDTH-1:0]        duty_reg;
   logic [WIDTH-1:0]        duty_next;
   logic [WIDTH-1:0]        duty_new;
   logic [WIDTH:0]          cmd_ext;
   logic [WIDTH:0]          abs_val;
   logic [WIDTH:0]          mag;
   logic [PW-1:0]           product;
   logic                    sat_new;
   logic                    start;
   logic                    reversal;
   logic                    pwm_a_next;
   logic                    pwm_b_next;

   // Period counter: the first edge out of reset is itself a period start,
   // so the counter sits at 0 for that edge instead of advancing.
   always_comb begin
      start    = first_reg || (cnt_reg == LAST);
      cnt_next = start ? '0 : cnt_reg + WIDTH'(1);
   end

   // Shadow command -> magnitude, saturation flag, duty and target state.
   // Sign extension by one bit lets -2^(WIDTH-1) negate without overflow.
   always_comb begin
      cmd_ext  = {shadow_reg[WIDTH-1], shadow_reg};
      abs_val  = shadow_reg[WIDTH-1] ? (~cmd_ext + (WIDTH+1)'(1)) : cmd_ext;
      sat_new  = (abs_val > FULL);
      mag      = sat_new ? FULL : abs_val;
      product  = PW'(mag) * PW'(PERIOD);
      duty_new = WIDTH'(product >> QBITS);
      if (duty_new == '0 || shadow_reg == '0) begin
         target_new = IDLE;
      end else if (shadow_reg[WIDTH-1]) begin
         target_new = REV;
      end else begin
         target_new = FWD;
      end
   end

   // Next state. DEAD is only entered at a period start (k = 0) and is left
   // once the counter reaches DEADTIME, so the counter doubles as the
   // dead-time timer.
   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      duty_next   = duty_reg;
      reversal    = ((state_reg == FWD) && (target_new == REV)) ||
                    ((state_reg == REV) && (target_new == FWD));
      if (!i_enable) begin
         state_next = IDLE;
      end else if (start) begin
         duty_next   = duty_new;
         target_next = target_new;
         if (DEADTIME != 0 && reversal) begin
            state_next = DEAD;
         end else begin
            state_next = target_new;
         end
      end else if (state_reg == DEAD && cnt_next >= DEAD_W) begin
         state_next = target_reg;
      end
      // Legs are decoded from a single state, so they can never overlap.
      pwm_a_next = (state_next == FWD) && (cnt_next < duty_next);
      pwm_b_next = (state_next == REV) && (cnt_next < duty_next);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         first_reg      <= 1'b1;
         cnt_reg        <= '0;
         shadow_reg     <= '0;
         state_reg      <= IDLE;
         target_reg     <= IDLE;
         duty_reg       <= '0;
         o_pwm_a        <= 1'b0;
         o_pwm_b        <= 1'b0;
         o_dir          <= 1'b0;
         o_sat          <= 1'b0;
         o_period_start <= 1'b0;
      end else begin
         first_reg      <= 1'b0;
         cnt_reg        <= cnt_next;
         // Captured value is only seen by the next start edge, so a capture
         // coinciding with a start is deferred by one period.
         if (i_cmd_valid) begin
            shadow_reg <= i_cmd;
         end
         state_reg      <= state_next;
         target_reg     <= target_next;
         duty_reg       <= duty_next;
         o_pwm_a        <= pwm_a_next;
         o_pwm_b        <= pwm_b_next;
         o_period_start <= start;
         if (start) begin
            o_sat <= sat_new;
         end
         // Direction follows only a real drive target; IDLE keeps the last one.
         if (start && i_enable && target_new != IDLE) begin
            o_dir <= (target_new == REV);
         end
      end
   end

endmodule

// File: tb/tb_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_pwm_driver
//
// Directed bench for pwm_driver with default parameters (PERIOD=256,
// QBITS=8, DEADTIME=4). Each period's expected leg statistics are queued
// before the period runs and compared when the period has been observed.
// ---------------------------------------------------------------------------
module tb_pwm_driver;

   logic               i_clk = 1'b0;
   logic               i_rst_n;
   logic signed [15:0] i_cmd;
   logic               i_cmd_valid;
   logic               i_enable;
   logic               o_pwm_a;
   logic               o_pwm_b;
   logic               o_dir;
   logic               o_sat;
   logic               o_period_start;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      int    a_cnt;
      int    b_cnt;
      int    lead;
      logic  dir;
      logic  sat;
   } exp_t;

   // kind: 1 = capture cmd, 2 = disable, 3 = enable
   typedef struct {
      int          k;
      int          kind;
      logic [15:0] cmd;
   } act_t;

   exp_t exp_q[$];
   act_t act_q[$];

   pwm_driver dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_cmd          (i_cmd),
      .i_cmd_valid    (i_cmd_valid),
      .i_enable       (i_enable),
      .o_pwm_a        (o_pwm_a),
      .o_pwm_b        (o_pwm_b),
      .o_dir          (o_dir),
      .o_sat          (o_sat),
      .o_period_start (o_period_start)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_period(input string name, input int a, input int b,
                                input int lead, input logic dir, input logic sat);
      exp_t e;
      e.name = name; e.a_cnt = a; e.b_cnt = b; e.lead = lead; e.dir = dir; e.sat = sat;
      exp_q.push_back(e);
   endtask

   task automatic add_act(input int k, input int kind, input logic [15:0] cmd);
      act_t a;
      a.k = k; a.kind = kind; a.cmd = cmd;
      act_q.push_back(a);
   endtask

   // Called at the falling edge of cycle k=0 of a period; returns at the
   // falling edge of k=0 of the following period.
   task automatic run_period();
      exp_t e;
      int   a_cnt  = 0;
      int   b_cnt  = 0;
      int   lead   = 256;
      int   ps_ok  = 0;
      int   dir_ok = 0;
      int   sat_ok = 0;
      check("exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
      end else begin
         e.name = "none"; e.a_cnt = -1; e.b_cnt = -1; e.lead = -1; e.dir = 1'bx; e.sat = 1'bx;
      end
      for (int k = 0; k < 256; k++) begin
         check($sformatf("%s.onehot_k%0d", e.name, k), 32'(o_pwm_a & o_pwm_b), 32'(0));
         if (o_pwm_a === 1'b1) a_cnt++;
         if (o_pwm_b === 1'b1) b_cnt++;
         if ((o_pwm_a === 1'b1 || o_pwm_b === 1'b1) && lead == 256) lead = k;
         if (o_period_start === (k == 0)) ps_ok++;
         if (o_dir === e.dir) dir_ok++;
         if (o_sat === e.sat) sat_ok++;
         i_cmd_valid = 1'b0;
         while (act_q.size() > 0 && act_q[0].k == k) begin
            case (act_q[0].kind)
               1: begin i_cmd = act_q[0].cmd; i_cmd_valid = 1'b1; end
               2: i_enable = 1'b0;
               3: i_enable = 1'b1;
               default: ;
            endcase
            void'(act_q.pop_front());
         end
         @(negedge i_clk);
      end
      i_cmd_valid = 1'b0;
      check({e.name, ".a_cnt"}, a_cnt, e.a_cnt);
      check({e.name, ".b_cnt"}, b_cnt, e.b_cnt);
      check({e.name, ".lead"}, lead, e.lead);
      check({e.name, ".period_start_cycles_ok"}, ps_ok, 256);
      check({e.name, ".dir_cycles_ok"}, dir_ok, 256);
      check({e.name, ".sat_cycles_ok"}, sat_ok, 256);
      $display("period %s: a=%0d b=%0d lead=%0d dir=%0b sat=%0b", e.name, a_cnt, b_cnt, lead, o_dir, o_sat);
   endtask

   initial begin
      i_rst_n     = 1'b0;
      i_enable    = 1'b1;
      i_cmd       = '0;
      i_cmd_valid = 1'b0;

      // Reset state
      #23;
      check("rst.pwm_a", o_pwm_a, 0);
      check("rst.pwm_b", o_pwm_b, 0);
      check("rst.dir", o_dir, 0);
      check("rst.sat", o_sat, 0);
      check("rst.period_start", o_period_start, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("first_edge.period_start", o_period_start, 1);

      // P0 idle; P1 half duty forward
      add_act(10, 1, 16'h0080);
      expect_period("p0_idle", 0, 0, 256, 1'b0, 1'b0);
      run_period();
      add_act(10, 1, 16'h0100);
      expect_period("p1_half", 128, 0, 0, 1'b0, 1'b0);
      run_period();
      // Full forward then reversal with dead time
      add_act(10, 1, 16'hFF00);
      expect_period("p2_full_fwd", 256, 0, 0, 1'b0, 1'b0);
      run_period();
      add_act(10, 1, 16'h8000);
      expect_period("p3_rev_dead", 0, 252, 4, 1'b1, 1'b0);
      run_period();
      // Most-negative command saturates; REV->REV has no dead time
      add_act(10, 1, 16'h0000);
      expect_period("p4_neg_sat", 0, 256, 0, 1'b1, 1'b1);
      run_period();
      // Zero command: idle, direction retained
      add_act(10, 1, 16'h0180);
      expect_period("p5_zero", 0, 0, 256, 1'b1, 1'b0);
      run_period();
      // Over-range positive from IDLE: saturated, no dead time
      add_act(10, 1, 16'h0040);
      add_act(200, 1, 16'h00C0);
      expect_period("p6_pos_sat", 256, 0, 0, 1'b0, 1'b1);
      run_period();
      // Last capture wins; capture on the start edge is deferred
      add_act(255, 1, 16'h0080);
      expect_period("p7_last_wins", 192, 0, 0, 1'b0, 1'b0);
      run_period();
      expect_period("p8_deferred", 192, 0, 0, 1'b0, 1'b0);
      run_period();
      expect_period("p9_applied", 128, 0, 0, 1'b0, 1'b0);
      run_period();
      // Disable at counter 50, re-enable mid-period
      add_act(50, 2, 16'h0000);
      add_act(100, 3, 16'h0000);
      expect_period("p10_disable", 51, 0, 0, 1'b0, 1'b0);
      run_period();
      add_act(10, 1, 16'hFF80);
      expect_period("p11_reenable", 128, 0, 0, 1'b0, 1'b0);
      run_period();
      expect_period("p12_fwd_to_rev", 0, 124, 4, 1'b1, 1'b0);
      run_period();

      // Reset asserted mid-pulse in the following period
      for (int i = 0; i < 20; i++) @(negedge i_clk);
      check("pre_rst.pwm_b", o_pwm_b, 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_rst.pwm_a", o_pwm_a, 0);
      check("async_rst.pwm_b", o_pwm_b, 0);
      check("async_rst.dir", o_dir, 0);
      check("async_rst.sat", o_sat, 0);
      check("async_rst.period_start", o_period_start, 0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      add_act(10, 1, 16'h0080);
      expect_period("p13_post_rst_idle", 0, 0, 256, 1'b0, 1'b0);
      run_period();
      expect_period("p14_post_rst_half", 128, 0, 0, 1'b0, 1'b0);
      run_period();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
